hazard_tag_pipe: RTL and testbench

//  Producer side of the hazard interface. Decodes instr_D into register-use tags (rs/rt/rd/A3/res) and carries
//  the writer tags down the E, M and W stages. The hazard unit consumes these tags and returns stall.
//  On stall, this block inserts an NW bubble into E.

---
 rtl/hazard_tag_pipe_pkg.sv | 55 +++++
 rtl/hazard_tag_pipe_decode.sv | 65 ++++++
 rtl/hazard_tag_pipe.sv | 103 ++++++++++
 tb/tb_hazard_tag_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_tag_pipe_pkg.sv
// Shared hazard-interface definitions: result classes, opcode/funct constants and stage tag layouts.
// The hazard unit imports the same package so both sides agree on encodings.
package hazard_defs;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    res_e       res;
  } tag_e_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] a3;
    res_e       res;
  } tag_m_t;

  typedef struct packed {
    logic [4:0] a3;
    res_e       res;
  } tag_w_t;

  localparam tag_e_t BUBBLE_E = '{rs: 5'd0, rt: 5'd0, a3: 5'd0, res: RES_NW};
  localparam tag_m_t BUBBLE_M = '{rt: 5'd0, a3: 5'd0, res: RES_NW};
  localparam tag_w_t BUBBLE_W = '{a3: 5'd0, res: RES_NW};

  // A write to $0 is architecturally a no-op, so it must never look like a producer.
  function automatic res_e normalise_res(input logic [4:0] a3, input res_e res);
    return (a3 == REG_ZERO) ? RES_NW : res;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_decode.sv
// Combinational instruction decode into register-use tags (rs/rt/rd, destination A3, result class).
module instr_tag_decode
  import hazard_defs::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  a3,
  output res_e        res
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] a3_raw;
  res_e       res_raw;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    a3_raw  = REG_ZERO;
    res_raw = RES_NW;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          a3_raw  = rd;
          res_raw = RES_ALU;
        end else if (funct == FN_JR) begin
          a3_raw  = REG_ZERO;
          res_raw = RES_NW;
        end
      end
      OP_ORI, OP_LUI: begin
        a3_raw  = rt;
        res_raw = RES_ALU;
      end
      OP_LW: begin
        a3_raw  = rt;
        res_raw = RES_DM;
      end
      OP_JAL: begin
        a3_raw  = REG_RA;
        res_raw = RES_PC;
      end
      OP_SW, OP_BEQ, OP_J: begin
        a3_raw  = REG_ZERO;
        res_raw = RES_NW;
      end
      default: begin
        a3_raw  = REG_ZERO;
        res_raw = RES_NW;
      end
    endcase
  end

  assign a3  = a3_raw;
  assign res = normalise_res(a3_raw, res_raw);

endmodule

// File: rtl/hazard_tag_pipe.sv
// Producer side of the hazard interface: carries writer tags through E/M/W, bubbles E on stall,
// and keeps stall statistics (saturating total plus a sticky flag for over-long stall runs).
module hazard_tag_pipe
  import hazard_defs::*;
#(
  parameter int CNT_W         = 16,
  parameter int MAX_STALL_RUN = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instr_D,
  input  logic             stall,
  output logic [4:0]       rs_D,
  output logic [4:0]       rt_D,
  output logic [4:0]       rd_D,
  output logic [1:0]       res_D,
  output logic [4:0]       rs_E,
  output logic [4:0]       rt_E,
  output logic [4:0]       A3_E,
  output logic [4:0]       A3_M,
  output logic [4:0]       A3_W,
  output logic [1:0]       res_E,
  output logic [1:0]       res_M,
  output logic [1:0]       res_W,
  output logic [4:0]       rt_M,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_overrun
);

  localparam int                RUN_W   = $clog2(MAX_STALL_RUN + 2);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL_RUN);
  localparam logic [RUN_W-1:0]  RUN_SAT = RUN_W'(MAX_STALL_RUN + 1);

  logic [4:0]       a3_D;
  res_e             res_d_e;
  tag_e_t           tag_e;
  tag_m_t           tag_m;
  tag_w_t           tag_w;
  logic [RUN_W-1:0] run_cnt;

  instr_tag_decode u_decode (
    .instr (instr_D),
    .rs    (rs_D),
    .rt    (rt_D),
    .rd    (rd_D),
    .a3    (a3_D),
    .res   (res_d_e)
  );

  assign res_D = res_d_e;

  // M and W never hold; only E sees the bubble, the D/PC freeze lives in the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_e <= BUBBLE_E;
      tag_m <= BUBBLE_M;
      tag_w <= BUBBLE_W;
    end else begin
      if (stall) begin
        tag_e <= BUBBLE_E;
      end else begin
        tag_e <= '{rs: rs_D, rt: rt_D, a3: a3_D, res: res_d_e};
      end
      tag_m <= '{rt: tag_e.rt, a3: tag_e.a3, res: tag_e.res};
      tag_w <= '{a3: tag_m.a3, res: tag_m.res};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt     <= '0;
      run_cnt       <= '0;
      stall_overrun <= 1'b0;
    end else if (stall) begin
      if (stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (run_cnt != RUN_SAT) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      // This edge takes the run past the legal maximum.
      if (run_cnt >= RUN_MAX) begin
        stall_overrun <= 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  assign rs_E  = tag_e.rs;
  assign rt_E  = tag_e.rt;
  assign A3_E  = tag_e.a3;
  assign res_E = tag_e.res;
  assign rt_M  = tag_m.rt;
  assign A3_M  = tag_m.a3;
  assign res_M = tag_m.res;
  assign A3_W  = tag_w.a3;
  assign res_W = tag_w.res;

  // An unknown stall would bubble E in hardware only by accident; flag it instead.
  a_stall_known : assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(stall));

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Randomised bench for hazard_tag_pipe against a stage-by-stage behavioural model.
module tb_hazard_tag_pipe;

  localparam int CNT_W   = 4;
  localparam int MAX_RUN = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic [31:0]      instr_D;
  logic             stall;
  logic [4:0]       rs_D, rt_D, rd_D, rs_E, rt_E, A3_E, A3_M, A3_W, rt_M;
  logic [1:0]       res_D, res_E, res_M, res_W;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_overrun;

  hazard_tag_pipe #(.CNT_W(CNT_W), .MAX_STALL_RUN(MAX_RUN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_D       (instr_D),
    .stall         (stall),
    .rs_D          (rs_D),
    .rt_D          (rt_D),
    .rd_D          (rd_D),
    .res_D         (res_D),
    .rs_E          (rs_E),
    .rt_E          (rt_E),
    .A3_E          (A3_E),
    .A3_M          (A3_M),
    .A3_W          (A3_W),
    .res_E         (res_E),
    .res_M         (res_M),
    .res_W         (res_W),
    .rt_M          (rt_M),
    .stall_cnt     (stall_cnt),
    .stall_overrun (stall_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rs;
    int rt;
    int a3;
    int res;
  } tag_t;

  tag_t me, mm, mw;
  int   m_cnt, m_run;
  int   m_ovr;
  int   checks, failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    me = '{0, 0, 0, 0};
    mm = '{0, 0, 0, 0};
    mw = '{0, 0, 0, 0};
    m_cnt = 0;
    m_run = 0;
    m_ovr = 0;
  endtask

  task automatic check_regs();
    check("rs_E", 32'(rs_E), me.rs);
    check("rt_E", 32'(rt_E), me.rt);
    check("A3_E", 32'(A3_E), me.a3);
    check("res_E", 32'(res_E), me.res);
    check("rt_M", 32'(rt_M), mm.rt);
    check("A3_M", 32'(A3_M), mm.a3);
    check("res_M", 32'(res_M), mm.res);
    check("A3_W", 32'(A3_W), mw.a3);
    check("res_W", 32'(res_W), mw.res);
    check("stall_cnt", 32'(stall_cnt), m_cnt);
    check("stall_overrun", 32'(stall_overrun), m_ovr);
  endtask

  // kind: 0 addu,1 subu,2 ori,3 lui,4 lw,5 jal,6 sw,7 beq,8 j,9 jr,10 undefined op,11 undefined funct
  task automatic gen(input int kind, output logic [31:0] ins, output int a3, output int res);
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op, fn;
    logic [15:0] imm;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    a3  = 0;
    res = 0;
    case (kind)
      0: begin ins = {6'h00, rs, rt, rd, 5'($urandom), 6'h21}; a3 = rd; res = 1; end
      1: begin ins = {6'h00, rs, rt, rd, 5'($urandom), 6'h23}; a3 = rd; res = 1; end
      2: begin ins = {6'h0D, rs, rt, imm}; a3 = rt; res = 1; end
      3: begin ins = {6'h0F, rs, rt, imm}; a3 = rt; res = 1; end
      4: begin ins = {6'h23, rs, rt, imm}; a3 = rt; res = 2; end
      5: begin ins = {6'h03, 26'($urandom)}; a3 = 31; res = 3; end
      6: ins = {6'h2B, rs, rt, imm};
      7: ins = {6'h04, rs, rt, imm};
      8: ins = {6'h02, 26'($urandom)};
      9: ins = {6'h00, rs, 15'd0, 6'h08};
      10: begin
        do op = 6'($urandom_range(1, 63));
        while (op == 6'h0D || op == 6'h0F || op == 6'h23 || op == 6'h03);
        ins = {op, 26'($urandom)};
      end
      default: begin
        do fn = 6'($urandom);
        while (fn == 6'h21 || fn == 6'h23);
        ins = {6'h00, rs, rt, rd, 5'($urandom), fn};
      end
    endcase
    if (a3 == 0) res = 0;
  endtask

  // Drive one cycle of D and stall, then advance the model across the edge and compare.
  task automatic step(input logic [31:0] ins, input int a3, input int res, input bit stl);
    instr_D = ins;
    stall   = stl;
    #1;
    check("rs_D", 32'(rs_D), 32'(ins[25:21]));
    check("rt_D", 32'(rt_D), 32'(ins[20:16]));
    check("rd_D", 32'(rd_D), 32'(ins[15:11]));
    check("res_D", 32'(res_D), res);
    @(posedge clk);
    mw.a3  = mm.a3;
    mw.res = mm.res;
    mm     = me;
    if (stl) me = '{0, 0, 0, 0};
    else     me = '{int'(ins[25:21]), int'(ins[20:16]), a3, res};
    if (stl) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_run++;
      if (m_run > MAX_RUN) m_ovr = 1;
    end else begin
      m_run = 0;
    end
    #1;
    check_regs();
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    #1 reset_n = 1'b1;
  endtask

  logic [31:0] ins;
  int          a3, res, run_left;
  bit          stl;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    instr_D  = '0;
    stall    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_regs();
    @(negedge clk);
    reset_n = 1'b1;

    // addu $6,$1,$2 followed by NOPs walks through E, M, W
    step({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h21}, 6, 1, 0);
    repeat (3) step(32'h0, 0, 0, 0);
    // jal writes $ra; ori to $0 is normalised away
    step({6'h03, 26'h0000040}, 31, 3, 0);
    step({6'h0D, 5'd1, 5'd0, 16'd5}, 0, 0, 0);
    // lw $6 then one stall cycle bubbles E while lw moves to M
    step({6'h23, 5'd2, 5'd6, 16'h0004}, 6, 2, 0);
    step({6'h04, 5'd6, 5'd3, 16'h0010}, 0, 0, 1);
    step({6'h04, 5'd6, 5'd3, 16'h0010}, 0, 0, 0);
    // three back-to-back stalls trip the overrun flag, which stays after stall drops
    repeat (3) step(32'h0, 0, 0, 1);
    step(32'h0, 0, 0, 0);
    // long stall saturates the counter
    repeat (20) step(32'h0, 0, 0, 1);
    step({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h23}, 7, 1, 0);
    step({6'h23, 5'd2, 5'd9, 16'h0008}, 9, 2, 0);
    reset_pulse();
    step({6'h0F, 5'd0, 5'd4, 16'h1234}, 4, 1, 0);

    run_left = 0;
    for (int i = 0; i < 600; i++) begin
      gen($urandom_range(0, 11), ins, a3, res);
      if (run_left == 0 && $urandom_range(0, 7) == 0) run_left = $urandom_range(1, 4);
      stl = (run_left > 0);
      if (run_left > 0) run_left--;
      step(ins, a3, res, stl);
      if ($urandom_range(0, 149) == 0) reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
